// File: rtl/mux_pipe_n.sv
// mux_pipe_n
//    Parametrised N-input, WIDTH-bit selector with a registered output stage
//    and a valid/ready handshake on both sides. A main register drives the
//    outputs and a skid register absorbs the one item that can arrive while
//    in_ready is still high from the previous cycle. This gives one transfer
//    per cycle with a fully registered in_ready.
//
//    Out-of-range selects (sel >= N) capture zero data and set a per-item
//    error flag.
//
//    Optional feature macro: MUX_PIPE_ERRCNT_EN
//       When defined, the err_cnt port and its saturating counter exist.
//
// Parameters
//    WIDTH : data width of each channel and of out_data
//    N     : number of input channels (2..16)
//    SELW  : select width, 2**SELW >= N
//
// Ports
//    clk       in   clock, rising edge
//    reset     in   synchronous active-high reset
//    in_bus    in   N*WIDTH, channel k at [k*WIDTH +: WIDTH]
//    sel       in   SELW, channel index sampled on accept
//    in_valid  in   upstream offers in_bus/sel
//    in_ready  out  block can accept (registered)
//    flush     in   synchronous discard of buffered items
//    out_data  out  WIDTH, data of head item
//    out_err   out  head item was captured with sel >= N
//    out_valid out  head item valid
//    out_ready in   downstream accepts head item
//    err_cnt   out  8-bit saturating error count (MUX_PIPE_ERRCNT_EN only)
module mux_pipe_n #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in_bus,
   input  logic [SELW-1:0]      sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_err,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef MUX_PIPE_ERRCNT_EN
  ,output logic [7:0]           err_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [WIDTH-1:0]   main_data_r;
   logic               main_err_r;
   logic [WIDTH-1:0]   skid_data_r;
   logic               skid_err_r;
   logic               out_valid_r;
   logic               in_ready_r;

   logic               accept_s;
   logic               fire_s;
   logic [WIDTH-1:0]   cap_data_s;
   logic               cap_err_s;
   logic               load_main_new_s;
   logic               load_main_skid_s;
   logic               load_skid_s;

   // Picks channel s from the bus; out-of-range indices give zero.
   function automatic logic [WIDTH-1:0] select_channel(
      input logic [N*WIDTH-1:0] bus,
      input logic [SELW-1:0]    s
   );
      logic [WIDTH-1:0] d;
      d = {WIDTH{1'b0}};
      for (int k = 0; k < N; k++) begin
         if (32'(s) == 32'(k)) begin
            d = bus[k*WIDTH +: WIDTH];
         end
      end
      return d;
   endfunction

   // Flush blocks acceptance so an item offered in the flush cycle is dropped.
   assign accept_s   = in_valid & in_ready_r & ~flush;
   assign fire_s     = out_valid_r & out_ready;
   assign cap_data_s = select_channel(in_bus, sel);
   assign cap_err_s  = (32'(sel) >= 32'(N));

   assign out_data   = main_data_r;
   assign out_err    = main_err_r;
   assign out_valid  = out_valid_r;
   assign in_ready   = in_ready_r;

   // Next-state logic of the two-entry buffer.
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) state_nxt_s = ST_ONE;
               else          state_nxt_s = ST_EMPTY;
            end
            ST_ONE: begin
               if (fire_s && accept_s) state_nxt_s = ST_ONE;
               else if (fire_s)        state_nxt_s = ST_EMPTY;
               else if (accept_s)      state_nxt_s = ST_FULL;
               else                    state_nxt_s = ST_ONE;
            end
            ST_FULL: begin
               if (fire_s) state_nxt_s = ST_ONE;
               else        state_nxt_s = ST_FULL;
            end
            default: state_nxt_s = ST_EMPTY;
         endcase
      end
   end

   // Datapath load enables derived from the current state and handshakes.
   always_comb begin
      load_main_new_s  = 1'b0;
      load_main_skid_s = 1'b0;
      load_skid_s      = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            load_main_new_s = accept_s;
         end
         ST_ONE: begin
            load_main_new_s = accept_s & fire_s;
            load_skid_s     = accept_s & ~fire_s;
         end
         ST_FULL: begin
            load_main_skid_s = fire_s & ~flush;
         end
         default: begin
            load_main_new_s  = 1'b0;
            load_main_skid_s = 1'b0;
            load_skid_s      = 1'b0;
         end
      endcase
   end

   // State register with in_ready/out_valid registered from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_EMPTY;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         out_valid_r <= (state_nxt_s != ST_EMPTY);
         in_ready_r  <= (state_nxt_s != ST_FULL);
      end
   end

   // Main and skid storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_data_r <= {WIDTH{1'b0}};
         main_err_r  <= 1'b0;
         skid_data_r <= {WIDTH{1'b0}};
         skid_err_r  <= 1'b0;
      end else begin
         if (load_main_new_s) begin
            main_data_r <= cap_data_s;
            main_err_r  <= cap_err_s;
         end else if (load_main_skid_s) begin
            main_data_r <= skid_data_r;
            main_err_r  <= skid_err_r;
         end
         if (load_skid_s) begin
            skid_data_r <= cap_data_s;
            skid_err_r  <= cap_err_s;
         end
      end
   end

`ifdef MUX_PIPE_ERRCNT_EN
   logic [7:0] err_cnt_r;

   // Saturating count of accepted out-of-range items; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_r <= 8'd0;
      end else if (accept_s && cap_err_s && (err_cnt_r != 8'd255)) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end
   end

   assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Testbench for mux_pipe_n (N=3, WIDTH=32, SELW=2 so sel=3 is out of range).
// A queue holds the items the bench expects the block to be buffering; items
// are pushed when an accept is driven and popped when the head fires.
module tb_mux_pipe_n;

   localparam int WIDTH = 32;
   localparam int N     = 3;
   localparam int SELW  = 2;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } item_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N*WIDTH-1:0]   in_bus;
   logic [SELW-1:0]      sel;
   logic                 in_valid;
   logic                 in_ready;
   logic                 flush;
   logic [WIDTH-1:0]     out_data;
   logic                 out_err;
   logic                 out_valid;
   logic                 out_ready;
`ifdef MUX_PIPE_ERRCNT_EN
   logic [7:0]           err_cnt;
`endif

   int    checks = 0;
   int    errors = 0;
   item_t exp_q[$];
   int    cnt_m = 0;
   bit    after_reset = 1'b0;
   bit    use_rand = 1'b0;

   always #5 clk = ~clk;

   mux_pipe_n #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_bus    (in_bus),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MUX_PIPE_ERRCNT_EN
     ,.err_cnt   (err_cnt)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: check outputs against the model, drive inputs, update model.
   task automatic cycle(input logic v, input logic [SELW-1:0] s, input logic r,
                        input logic f, input logic rs);
      item_t it;
      bit    acc;
      bit    fire;
      check_val("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      if (exp_q.size() > 0) begin
         check_val("out_data", out_data, exp_q[0].data);
         check_val("out_err", {31'd0, out_err}, {31'd0, exp_q[0].err});
      end
      if (after_reset) begin
         check_val("rst_out_data", out_data, 32'd0);
         check_val("rst_out_err", {31'd0, out_err}, 32'd0);
      end
`ifdef MUX_PIPE_ERRCNT_EN
      check_val("err_cnt", {24'd0, err_cnt}, 32'(cnt_m));
`endif
      in_valid  = v;
      sel       = s;
      out_ready = r;
      flush     = f;
      reset     = rs;
      if (use_rand) in_bus = {$urandom, $urandom, $urandom};
      else          in_bus = {32'h22222222, 32'h11111111, 32'h00000000};
      it.data = 32'd0;
      it.err  = (int'(s) >= N);
      for (int k = 0; k < N; k++) begin
         if (int'(s) == k) it.data = in_bus[k*WIDTH +: WIDTH];
      end
      acc  = v && (exp_q.size() < 2) && !f && !rs;
      fire = r && (exp_q.size() > 0);
      @(posedge clk);
      after_reset = rs;
      if (rs) begin
         exp_q.delete();
         cnt_m = 0;
      end else if (f) begin
         exp_q.delete();
      end else begin
         if (fire) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back(it);
            if (it.err && cnt_m < 255) cnt_m++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      sel       = 2'd0;
      out_ready = 1'b0;
      flush     = 1'b0;
      in_bus    = '0;
      @(posedge clk);
      @(negedge clk);
      after_reset = 1'b1;
      cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

      // Streaming with fixed channel values, including fire+accept in ONE.
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

      // Backpressure: A, B accepted, C held upstream until released.
      cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

      // Flush while FULL with an item offered, then the next accept.
      cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

      // Out-of-range selects until the error counter saturates.
      for (int i = 0; i < 300; i++) cycle(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

      // Random traffic with occasional flushes and random channel data.
      use_rand = 1'b1;
      for (int i = 0; i < 200; i++) begin
         cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 1'b0);
      end

      // Reset while FULL with error items buffered.
      cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_pipe_n.md
# mux_pipe_n

Parametrised N-input, WIDTH-bit selector with a registered, valid/ready-handshaked output. It replaces the fixed 3-way combinational 32-bit selectors wherever a selected operand must cross a pipeline boundary that can stall, such as the forwarding and result-select points in front of a stage register. It carries a two-entry skid buffer, so it sustains one transfer per cycle with a fully registered `in_ready`. Out-of-range selects yield zero data and raise a per-item error flag.

## Interface
Parameters:
- `WIDTH`, 32: data width of each input and of the output.
- `N`, 4: number of input channels, 2..16.
- `SELW`, 2: select width; must satisfy 2^SELW >= N.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_bus`  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `sel`  input  SELW  channel index, sampled with `in_bus` on acceptance.
- `in_valid`  input  1  upstream offers `in_bus` and `sel`.
- `in_ready`  output  1  block can accept; driven from a register.
- `flush`  input  1  synchronous discard of all buffered items.
- `out_data`  output  WIDTH  selected data of the head item.
- `out_err`  output  1  head item was captured with `sel` >= N.
- `out_valid`  output  1  head item is valid.
- `out_ready`  input  1  downstream accepts the head item.
- `err_cnt`  output  8  saturating error counter; present only with `MUX_PIPE_ERRCNT_EN`.

## Operation
- Accept occurs when `in_valid` and `in_ready` are both high. Fire occurs when `out_valid` and `out_ready` are both high.
- Captured value on accept:
  - `sel` < N: data = channel `sel`, err = 0.
  - `sel` >= N: data = 0, err = 1.
- Storage is a main register (drives the outputs) and a skid register. The state machine has three states:
  - EMPTY: accept -> main, go to ONE.
  - ONE:
    - fire and accept: main <= new item, stay in ONE.
    - fire only: go to EMPTY.
    - accept only: skid <= new item, go to FULL.
    - neither: hold.
  - FULL: `in_ready` = 0. On fire, main <= skid, go to ONE. Otherwise hold.
- `in_ready` is high in EMPTY and ONE, and low in FULL. It is computed as the registered next-state value.
- Output stability: while `out_valid` is high and `out_ready` is low, `out_data` and `out_err` hold unchanged.
- `flush`: next state is EMPTY and `in_ready` = 1.
  - An item offered in the flush cycle is not accepted and is not counted.
  - A fire in the same cycle still counts as delivered downstream.
- Priority: `reset` > `flush` > handshake.

## Timing
- Reset values:
  - `out_valid` = 0, `in_ready` = 1.
  - `out_data` = 0, `out_err` = 0.
  - skid contents = 0.
  - `err_cnt` = 0.
- Latency: an item accepted in cycle t appears on the outputs in cycle t+1 when the buffer was EMPTY, or when ONE with a fire in cycle t.
- Throughput: 1 item per cycle while `out_ready` stays high.
- The upstream sees backpressure one cycle after the second unfired accept. The skid register absorbs the item accepted during that cycle.
- Reset asserted mid-transfer discards both entries. The first accept is possible in the cycle after `reset` deasserts.
- There are no combinational paths from `out_ready` to `in_ready` or from `in_valid` to `out_valid`.

## Configuration
- `MUX_PIPE_ERRCNT_EN` defined:
  - `err_cnt` port exists.
  - It increments on every accepted item with `sel` >= N.
  - It saturates at 255 and clears only on `reset`; `flush` does not clear it.
- Undefined: the `err_cnt` port and its counter logic are absent. All other behaviour is identical.

## Test plan
- Streaming: N=4, WIDTH=32, channels = 0x11111111 ×k, `out_ready`=1, `sel` = 0,1,2,3 on consecutive cycles -> `out_data` = 0x00000000, 0x11111111, 0x22222222, 0x33333333 one cycle later, back-to-back, `in_ready` stays 1.
- Backpressure: `out_ready`=0, offer items A, B, C -> A and B accepted, `in_ready` drops after B, C held upstream. Release `out_ready` -> order A, B, C, with `out_data` stable while stalled.
- Out-of-range select: N=3, SELW=2, `sel`=3 -> `out_data`=0, `out_err`=1. With the macro, `err_cnt`=1. After 300 such items, `err_cnt`=255.
- Flush while FULL: flush with `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1, offered item dropped. The next accept appears 1 cycle later.
- Reset mid-stream: assert `reset` while FULL -> all outputs at reset values next cycle, including `err_cnt`=0.
- Simultaneous fire+accept in ONE: head replaced by the new item in one cycle, no bubble and no duplicate.
